// File: rtl/ram_output_ctrl.sv
// Owns every control input of the 16x8 output RAM: sequences a full-array clear,
// arbitrates the single address port between the compute write client and the host read client.
module ram_output_ctrl #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 4,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VAL      = '0,
    parameter int                    CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_rsp_valid,
    output logic [DATA_WIDTH-1:0] rd_rsp_data,
    input  logic                  clr_start,
    output logic                  busy,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    typedef enum logic [1:0] {CLEAR, IDLE, RD_ADDR, RD_CAP} state_t;
    typedef enum logic {CLIENT_WR, CLIENT_RD} client_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;
    localparam state_t                RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

    state_t                state_reg;
    client_t               rr_last_reg;
    logic [ADDR_WIDTH-1:0] clr_cnt_reg;
    logic                  clr_pending_reg;
    logic                  hold;
    logic                  wr_acc;
    logic                  rd_acc;

    // A clear request (new or pending) blocks both clients in the same cycle it is seen.
    assign hold   = clr_start | clr_pending_reg;
    assign wr_acc = wr_valid & wr_ready;
    assign rd_acc = rd_valid & rd_ready;
    assign busy   = (state_reg == CLEAR) | clr_pending_reg;

    always_comb begin
        wr_ready = 1'b0;
        rd_ready = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!hold) begin
                    if (wr_valid && rd_valid) begin
                        wr_ready = (rr_last_reg == CLIENT_RD);
                        rd_ready = (rr_last_reg == CLIENT_WR);
                    end else begin
                        wr_ready = wr_valid;
                        rd_ready = rd_valid;
                    end
                end
            end
            // Read address is already in the RAM (or about to be), so writes may slip in.
            RD_ADDR, RD_CAP: wr_ready = wr_valid & ~hold;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= RESET_STATE;
            rr_last_reg     <= CLIENT_RD;
            clr_cnt_reg     <= '0;
            clr_pending_reg <= 1'b0;
            ram_we          <= 1'b0;
            ram_addr        <= '0;
            ram_data        <= '0;
            rd_rsp_valid    <= 1'b0;
            rd_rsp_data     <= '0;
        end else begin
            ram_we       <= 1'b0;
            rd_rsp_valid <= 1'b0;
            if (wr_acc) begin
                ram_we      <= 1'b1;
                ram_addr    <= wr_addr;
                ram_data    <= wr_data;
                rr_last_reg <= CLIENT_WR;
            end
            if (rd_acc) begin
                ram_addr    <= rd_addr;
                rr_last_reg <= CLIENT_RD;
            end
            case (state_reg)
                CLEAR: begin
                    ram_we   <= 1'b1;
                    ram_addr <= clr_cnt_reg;
                    ram_data <= CLEAR_VAL;
                    if (clr_cnt_reg == LAST_ADDR) begin
                        state_reg       <= IDLE;
                        clr_cnt_reg     <= '0;
                        clr_pending_reg <= 1'b0;
                    end else begin
                        clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    end
                end
                IDLE: begin
                    if (clr_start) begin
                        state_reg <= CLEAR;
                    end else if (rd_acc) begin
                        state_reg <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (clr_start) begin
                        clr_pending_reg <= 1'b1;
                    end
                    state_reg <= RD_CAP;
                end
                RD_CAP: begin
                    rd_rsp_valid <= 1'b1;
                    rd_rsp_data  <= ram_q;
                    if (hold) begin
                        clr_pending_reg <= 1'b1;
                        state_reg       <= CLEAR;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= RESET_STATE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_output_ctrl.sv
// Directed + randomized bench for ram_output_ctrl with a behavioural RAM and a
// word-level reference memory tracking what every read must return.
module tb_ram_output_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid, wr_ready, rd_valid, rd_ready;
    logic [3:0] wr_addr, rd_addr, ram_addr;
    logic [7:0] wr_data, rd_rsp_data, ram_data, ram_q;
    logic       rd_rsp_valid, clr_start, busy, ram_we;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ref_mem [16];
    logic [7:0] mem [16];
    logic [3:0] addr_q;
    logic       ram_scramble;

    always #5 clk = ~clk;

    ram_output_ctrl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .CLEAR_VAL(8'h00), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
        .clr_start(clr_start), .busy(busy),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .ram_q(ram_q)
    );

    // RAM model: synchronous write, registered read address; scramble fills junk so a missed clear shows.
    always @(posedge clk) begin
        if (ram_scramble) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'(i * 37 + 11);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_data;
        end
        addr_q <= ram_addr;
    end
    assign ram_q = mem[addr_q];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals;
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_rd_ready", 32'(rd_ready), 0);
        chk("rst_rsp_valid", 32'(rd_rsp_valid), 0);
        chk("rst_rsp_data", 32'(rd_rsp_data), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_data", 32'(ram_data), 0);
        chk("rst_busy", 32'(busy), 1);
    endtask

    // Expects the DUT to be in CLEAR with the next edge issuing address 0.
    task automatic clear_seq;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1; wr_addr = 4'($urandom); wr_data = 8'($urandom);
            rd_valid = 1'b1; rd_addr = 4'($urandom);
            #1;
            chk("clr_busy", 32'(busy), 1);
            chk("clr_wr_ready", 32'(wr_ready), 0);
            chk("clr_rd_ready", 32'(rd_ready), 0);
            tick;
            chk("clr_we", 32'(ram_we), 1);
            chk("clr_addr", 32'(ram_addr), 32'(i));
            chk("clr_data", 32'(ram_data), 0);
            chk("clr_no_rsp", 32'(rd_rsp_valid), 0);
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        #1;
        chk("clr_done_busy", 32'(busy), 0);
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        $display("clear sequence: 16 words cleared");
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        #1;
        chk("wr_ready", 32'(wr_ready), 1);
        tick;
        wr_valid = 1'b0;
        chk("wr_we", 32'(ram_we), 1);
        chk("wr_addr", 32'(ram_addr), 32'(a));
        chk("wr_data", 32'(ram_data), 32'(d));
        ref_mem[a] = d;
        $display("write addr=%0d data=%02h", a, d);
    endtask

    task automatic do_read(input logic [3:0] a);
        logic [7:0] exp;
        rd_valid = 1'b1; rd_addr = a;
        #1;
        chk("rd_ready", 32'(rd_ready), 1);
        tick;
        rd_valid = 1'b0;
        exp = ref_mem[a];
        chk("rd_we_low", 32'(ram_we), 0);
        chk("rd_addr", 32'(ram_addr), 32'(a));
        chk("rd_rsp_early0", 32'(rd_rsp_valid), 0);
        tick;
        chk("rd_rsp_early1", 32'(rd_rsp_valid), 0);
        tick;
        chk("rd_rsp_valid", 32'(rd_rsp_valid), 1);
        chk("rd_rsp_data", 32'(rd_rsp_data), 32'(exp));
        tick;
        chk("rd_rsp_pulse", 32'(rd_rsp_valid), 0);
        chk("rd_rsp_hold", 32'(rd_rsp_data), 32'(exp));
        $display("read addr=%0d data=%02h expected=%02h", a, rd_rsp_data, exp);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [3:0] wa, ra, a;
        logic [7:0] wd, pend_data;
        bit         exp_wr_grant [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int         pend_due, n_rsp;

        rst = 1'b1; ram_scramble = 1'b1; clr_start = 1'b0;
        wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = '0; rd_addr = '0; wr_data = '0;
        tick;
        tick;
        ram_scramble = 1'b0;
        chk_reset_vals();
        rst = 1'b0;
        clear_seq();

        // Post-clear readback proves the clear reached the RAM.
        do_read(4'd5);

        // Both clients always requesting: grants follow W R W W R W.
        wa = 4'($urandom); wd = 8'($urandom); ra = 4'($urandom);
        pend_due = -1; pend_data = '0; n_rsp = 0;
        for (int cyc = 0; cyc < 9; cyc++) begin
            wr_valid = (cyc < 6); rd_valid = (cyc < 6);
            wr_addr = wa; wr_data = wd; rd_addr = ra;
            #1;
            if (cyc < 6) begin
                chk("cont_wr_ready", 32'(wr_ready), 32'(exp_wr_grant[cyc]));
                chk("cont_rd_ready", 32'(rd_ready), 32'(!exp_wr_grant[cyc]));
            end
            tick;
            if (cyc < 6 && exp_wr_grant[cyc]) begin
                chk("cont_wr_addr", 32'(ram_addr), 32'(wa));
                ref_mem[wa] = wd;
                $display("contention cycle %0d: write addr=%0d data=%02h", cyc, wa, wd);
                wa = 4'($urandom); wd = 8'($urandom);
            end else if (cyc < 6) begin
                pend_due = cyc + 2; pend_data = ref_mem[ra];
                $display("contention cycle %0d: read addr=%0d", cyc, ra);
                ra = 4'($urandom);
            end
            chk("cont_we", 32'(ram_we), 32'(cyc < 6 && exp_wr_grant[cyc]));
            chk("cont_rsp_valid", 32'(rd_rsp_valid), 32'(cyc == pend_due));
            if (cyc == pend_due) begin
                chk("cont_rsp_data", 32'(rd_rsp_data), 32'(pend_data));
                n_rsp++;
            end
        end
        chk("cont_rsp_count", 32'(n_rsp), 2);

        // Write then read of the same address on the next cycle.
        do_write(4'd3, 8'hA5);
        do_read(4'd3);

        for (int i = 0; i < 30; i++) begin
            a = 4'($urandom);
            if ($urandom_range(1, 0) == 1) do_write(a, 8'($urandom));
            else do_read(a);
        end

        for (int i = 0; i < 16; i++) do_write(4'(i), 8'(i) ^ 8'hFF);
        for (int i = 0; i < 16; i++) do_read(4'(i));

        // Clear request arriving while a read is in RD_ADDR.
        do_write(4'd7, 8'h3C);
        rd_valid = 1'b1; rd_addr = 4'd7;
        #1;
        chk("cdr_rd_ready", 32'(rd_ready), 1);
        tick;
        rd_valid = 1'b0;
        clr_start = 1'b1; wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 8'h11;
        #1;
        chk("cdr_wr_blocked", 32'(wr_ready), 0);
        chk("cdr_rd_blocked", 32'(rd_ready), 0);
        tick;
        clr_start = 1'b0; wr_valid = 1'b0;
        chk("cdr_busy_pending", 32'(busy), 1);
        chk("cdr_no_write", 32'(ram_we), 0);
        tick;
        chk("cdr_rsp_valid", 32'(rd_rsp_valid), 1);
        chk("cdr_rsp_data", 32'(rd_rsp_data), 32'h3C);
        chk("cdr_busy", 32'(busy), 1);
        $display("clear during read: rsp data=%02h", rd_rsp_data);
        clear_seq();
        do_read(4'd7);

        // Clear request in IDLE blocks that cycle's requests.
        do_write(4'd4, 8'h5A);
        clr_start = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1;
        #1;
        chk("cidle_wr_blocked", 32'(wr_ready), 0);
        chk("cidle_rd_blocked", 32'(rd_ready), 0);
        tick;
        clr_start = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
        chk("cidle_busy", 32'(busy), 1);
        chk("cidle_no_write", 32'(ram_we), 0);
        clear_seq();
        do_read(4'd4);

        // Reset while a read sits in RD_ADDR drops the read.
        do_write(4'd9, 8'hC3);
        rd_valid = 1'b1; rd_addr = 4'd9;
        #1;
        tick;
        rd_valid = 1'b0;
        rst = 1'b1;
        tick;
        chk_reset_vals();
        tick;
        chk("rst_no_rsp", 32'(rd_rsp_valid), 0);
        $display("reset mid-read: rsp_valid=%0d", rd_rsp_valid);
        rst = 1'b0;
        clear_seq();
        do_read(4'd9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
